banked_memory: RTL and testbench

//  Parametrised on-chip byte-addressed RAM. Successor of the single-byte memory: configurable bus width,

---
 rtl/banked_memory_if.sv | 37 +++
 rtl/banked_memory.sv | 200 ++++++++++++++++++++
 tb/tb_banked_memory.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/banked_memory_if.sv
// ---------------------------------------------------------------------------
// banked_memory_if
//   Load/store bus between a requester and banked_memory.
//   Signals:
//     addr             byte address of the access
//     data_in          write data, lane k carries byte addr+k
//     byte_en          per-lane write strobes
//     data_out         read data (last successful read)
//     memory_read_en   read request, held until ready
//     memory_write_en  write request, held until ready
//     ready            one-cycle completion pulse
//     error            qualifies ready: access was rejected
//   Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface banked_memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_BYTES  = 4
);
  logic [ADDR_WIDTH-1:0]  addr;
  logic [8*BUS_BYTES-1:0] data_in;
  logic [BUS_BYTES-1:0]   byte_en;
  logic [8*BUS_BYTES-1:0] data_out;
  logic                   memory_read_en;
  logic                   memory_write_en;
  logic                   ready;
  logic                   error;

  modport master (
    output addr, data_in, byte_en, memory_read_en, memory_write_en,
    input  data_out, ready, error
  );

  modport slave (
    input  addr, data_in, byte_en, memory_read_en, memory_write_en,
    output data_out, ready, error
  );
endinterface

// File: rtl/banked_memory.sv
// ---------------------------------------------------------------------------
// banked_memory
//   Byte-addressed on-chip RAM built from BUS_BYTES independent 8-bit banks
//   (each one an inferable block RAM with registered read). Accepts one
//   read or write at a time through a level request / ready-pulse handshake
//   and rejects illegal accesses with an error response.
//
//   Ports:
//     clk   clock, all logic on the rising edge
//     rst   synchronous active-high reset (RAM contents are not cleared)
//     bus   banked_memory_if.slave: addr, data_in, byte_en, data_out,
//           memory_read_en, memory_write_en, ready, error
//
//   Timing (E0 = edge on which the request is accepted in IDLE):
//     write / any error : ready after E1
//     read              : ready and new data_out after E(READ_LATENCY)
//
//   Build option: define MEM_INIT_PATTERN_EN to preload byte i with i[7:0]
//   at time 0 (test pattern). Without it the RAM has no initial contents.
// ---------------------------------------------------------------------------
module banked_memory #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_BYTES  = 4096,
  parameter int BUS_BYTES    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  banked_memory_if.slave   bus
);

  localparam int WORDS     = DEPTH_BYTES / BUS_BYTES;
  localparam int LANE_BITS = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 0;
  localparam int WORD_AW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Low address bits that must be zero for an aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BUS_BYTES - 1);
  // Range check is done at 64 bits so neither side is truncated.
  localparam logic [63:0] DEPTH_LIMIT = 64'(DEPTH_BYTES);
  // Number of RD_PIPE cycles a read spends before its RESP cycle.
  localparam logic [1:0] PIPE_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PIPE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;

  // Request decode
  logic               accept;
  logic               req_read_only;
  logic               req_write_only;
  logic               req_both;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;
  logic               ram_we;
  logic               ram_re;
  logic [WORD_AW-1:0] word_idx;

  // Response bookkeeping
  logic                   ready_reg;
  logic                   error_reg;
  logic                   err_pend_reg;
  logic                   rd_pend_reg;
  logic [8*BUS_BYTES-1:0] data_out_reg;
  logic [8*BUS_BYTES-1:0] rd_word;

  // -------------------------------------------------------------------------
  // Request decode. Requests are looked at only in IDLE; during reset nothing
  // is accepted so the RAM cannot be written while the FSM is being cleared.
  // -------------------------------------------------------------------------
  assign req_read_only  = bus.memory_read_en & ~bus.memory_write_en;
  assign req_write_only = bus.memory_write_en & ~bus.memory_read_en;
  assign req_both       = bus.memory_read_en & bus.memory_write_en;

  assign accept = ~rst & (state_reg == IDLE) &
                  (bus.memory_read_en | bus.memory_write_en);

  assign misaligned   = |(bus.addr & ALIGN_MASK);
  assign out_of_range = (64'(bus.addr) >= DEPTH_LIMIT);
  assign req_err      = req_both | misaligned | out_of_range;

  assign ram_we = accept & req_write_only & ~req_err;
  assign ram_re = accept & req_read_only & ~req_err;

  // Only meaningful when the address is in range, which gates every use.
  assign word_idx = bus.addr[LANE_BITS +: WORD_AW];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. Every access ends with exactly one RESP cycle; ready is
  // raised on the edge that leaves RESP, so a write or an error reaches RESP
  // straight from IDLE, and a read first waits READ_LATENCY-1 RD_PIPE cycles.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (ram_re && (READ_LATENCY > 1)) begin
            state_next = RD_PIPE;
            cnt_next   = 2'd1;
          end else begin
            state_next = RESP;
          end
        end
      end
      RD_PIPE: begin
        if (cnt_reg == PIPE_LAST) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Response registers. The kind of access is latched on accept so that the
  // RESP exit edge knows whether to flag an error or to publish read data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg    <= 1'b0;
      error_reg    <= 1'b0;
      err_pend_reg <= 1'b0;
      rd_pend_reg  <= 1'b0;
      data_out_reg <= '0;
    end else begin
      ready_reg <= (state_reg == RESP);
      error_reg <= (state_reg == RESP) & err_pend_reg;
      if (accept) begin
        err_pend_reg <= req_err;
        rd_pend_reg  <= req_read_only & ~req_err;
      end
      if ((state_reg == RESP) && rd_pend_reg) begin
        data_out_reg <= rd_word;
      end
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.error    = error_reg;
  assign bus.data_out = data_out_reg;

  // -------------------------------------------------------------------------
  // Storage: one 8-bit bank per byte lane. The read register is loaded only
  // on an accepted read and then holds its value for the whole read pipeline,
  // so longer latencies need no extra data stages.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BUS_BYTES; gi++) begin : g_bank
      logic [7:0] bank_mem [WORDS];
      logic [7:0] rd_byte;

`ifdef MEM_INIT_PATTERN_EN
      initial begin
        for (int w = 0; w < WORDS; w++) begin
          bank_mem[w] = 8'(w * BUS_BYTES + gi);
        end
      end
`endif

      always_ff @(posedge clk) begin
        if (ram_we && bus.byte_en[gi]) begin
          bank_mem[word_idx] <= bus.data_in[8*gi +: 8];
        end
        if (ram_re) begin
          rd_byte <= bank_mem[word_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte;
    end
  endgenerate

endmodule

// File: tb/tb_banked_memory.sv
// ---------------------------------------------------------------------------
// tb_banked_memory
//   Two memories share one stimulus driver: one with READ_LATENCY=1 and one
//   with READ_LATENCY=3 (only the selected one sees its enables high).
//   A byte-array reference model predicts error, latency and data_out.
// ---------------------------------------------------------------------------
module tb_banked_memory;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  int          t_sel  = 0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_data = '0;
  logic [3:0]  t_be   = '0;
  logic        t_rd   = 1'b0;
  logic        t_wr   = 1'b0;

  banked_memory_if #(.ADDR_WIDTH(32), .BUS_BYTES(4)) bus_lat1 ();
  banked_memory_if #(.ADDR_WIDTH(32), .BUS_BYTES(4)) bus_lat3 ();

  assign bus_lat1.addr            = t_addr;
  assign bus_lat1.data_in         = t_data;
  assign bus_lat1.byte_en         = t_be;
  assign bus_lat1.memory_read_en  = t_rd & (t_sel == 0);
  assign bus_lat1.memory_write_en = t_wr & (t_sel == 0);
  assign bus_lat3.addr            = t_addr;
  assign bus_lat3.data_in         = t_data;
  assign bus_lat3.byte_en         = t_be;
  assign bus_lat3.memory_read_en  = t_rd & (t_sel == 1);
  assign bus_lat3.memory_write_en = t_wr & (t_sel == 1);

  banked_memory #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .BUS_BYTES(4), .READ_LATENCY(1)
  ) dut_lat1 (
    .clk(clk), .rst(rst), .bus(bus_lat1)
  );

  banked_memory #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .BUS_BYTES(4), .READ_LATENCY(3)
  ) dut_lat3 (
    .clk(clk), .rst(rst), .bus(bus_lat3)
  );

  // Reference model: plain byte arrays plus the last good read word
  logic [7:0]  mem_m  [2][DEPTH];
  logic [31:0] dout_m [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int sel, input logic [31:0] a);
    return {mem_m[sel][a+3], mem_m[sel][a+2], mem_m[sel][a+1], mem_m[sel][a]};
  endfunction

  // One complete handshake on the selected memory, checked against the model.
  task automatic do_access(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    int          n;
    logic        got_rdy;
    logic        got_err;
    logic [31:0] got_dout;
    logic        err_exp;
    int          lat_exp;

    @(negedge clk);
    t_sel = sel; t_addr = a; t_data = d; t_be = be; t_rd = rd; t_wr = wr;

    err_exp = (rd && wr) || (a[1:0] != 2'b00) || (a >= 32'(DEPTH));
    if (!err_exp && wr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_m[sel][a+k] = d[8*k +: 8];
      end
    end
    if (!err_exp && rd) dout_m[sel] = model_word(sel, a);
    lat_exp = (err_exp || wr) ? 1 : ((sel == 0) ? 1 : 3);

    @(posedge clk);  // accept edge
    n = 0;
    got_rdy = 1'b0;
    while (!got_rdy && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      got_rdy = (sel == 0) ? bus_lat1.ready : bus_lat3.ready;
    end
    got_err  = (sel == 0) ? bus_lat1.error : bus_lat3.error;
    got_dout = (sel == 0) ? bus_lat1.data_out : bus_lat3.data_out;
    t_rd = 1'b0;
    t_wr = 1'b0;

    $display("txn sel=%0d rd=%0d wr=%0d addr=%h data=%h be=%h -> edges=%0d err=%0d dout=%h",
             sel, rd, wr, a, d, be, n, got_err, got_dout);
    check_value("latency", 32'(n), 32'(lat_exp));
    check_value("error", {31'b0, got_err}, {31'b0, err_exp});
    check_value("data_out", got_dout, dout_m[sel]);
  endtask

  initial begin
    logic [31:0] a;
    logic [6:0]  pattern;
    logic        saw_ready;
    int          r;

    dout_m[0] = '0;
    dout_m[1] = '0;
`ifdef MEM_INIT_PATTERN_EN
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) mem_m[s][i] = 8'(i);
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_value("reset_ready", {31'b0, bus_lat1.ready | bus_lat3.ready}, 32'd0);
    check_value("reset_error", {31'b0, bus_lat1.error | bus_lat3.error}, 32'd0);
    check_value("reset_dout1", bus_lat1.data_out, 32'd0);
    check_value("reset_dout3", bus_lat3.data_out, 32'd0);

`ifdef MEM_INIT_PATTERN_EN
    do_access(0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
    check_value("init_pattern", bus_lat1.data_out, 32'h07060504);
`endif

    // Give every word the tests touch a known value
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) do_access(s, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
      do_access(s, 1'b0, 1'b1, 32'hFFC, $urandom, 4'hF);
    end

    // Full write then read back, both latencies
    for (int s = 0; s < 2; s++) begin
      do_access(s, 1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, 4'hF);
      do_access(s, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      check_value("full_word", (s == 0) ? bus_lat1.data_out : bus_lat3.data_out, 32'hA1B2C3D4);
      // Single-lane strobe
      do_access(s, 1'b0, 1'b1, 32'h10, 32'h0000EE00, 4'b0010);
      do_access(s, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      check_value("lane1_word", (s == 0) ? bus_lat1.data_out : bus_lat3.data_out, 32'hA1B2EED4);
    end

    // Errors: misaligned, first out-of-range byte, both enables
    do_access(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h0);
    do_access(0, 1'b1, 1'b0, 32'(DEPTH), 32'h0, 4'h0);
    do_access(1, 1'b1, 1'b0, 32'(DEPTH), 32'h0, 4'h0);
    do_access(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    // Last valid word and an empty strobe
    do_access(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
    do_access(0, 1'b0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0);
    do_access(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);

    // Reset one edge after a latency-3 read is accepted
    @(negedge clk);
    t_sel = 1; t_addr = 32'h40; t_rd = 1'b1; t_wr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t_rd = 1'b0;
    dout_m[0] = '0;
    dout_m[1] = '0;
    saw_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus_lat3.ready) saw_ready = 1'b1;
    end
    $display("txn mid-read reset sel=1 addr=00000040 -> ready_seen=%0d dout=%h",
             saw_ready, bus_lat3.data_out);
    check_value("rst_no_ready", {31'b0, saw_ready}, 32'd0);
    check_value("rst_dout3", bus_lat3.data_out, 32'd0);
    check_value("rst_dout1", bus_lat1.data_out, 32'd0);
    do_access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

    // Held read_en on the latency-1 memory: one response every second cycle
    @(negedge clk);
    t_sel = 0; t_addr = 32'h08; t_rd = 1'b1; t_wr = 1'b0;
    dout_m[0] = model_word(0, 32'h08);
    @(posedge clk);
    pattern = '0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      pattern[i] = bus_lat1.ready;
    end
    t_rd = 1'b0;
    $display("txn held read sel=0 addr=00000008 -> ready pattern=%b dout=%h",
             pattern, bus_lat1.data_out);
    check_value("b2b_ready", {25'b0, pattern}, {25'b0, 7'b1010101});
    check_value("b2b_dout", bus_lat1.data_out, dout_m[0]);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = {22'b0, 8'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) a = {22'b0, 8'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH) + 32'($urandom_range(0, 1000) * 4)
                                                        : 32'hFFFFFFFC;
      else             a = 32'hFFC;
      r = int'($urandom_range(0, 19));
      do_access(int'($urandom_range(0, 1)), (r < 9) || (r >= 18), (r >= 9),
                a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
